// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio
// and default frame format used by both transmit and receive ends.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional
// parity, stop bit(s); bit timing from the 16x baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = DEF_DBIT,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_din,
  output logic            o_tx,
  output logic            o_tx_done_tick,
  output logic            o_busy
);

  localparam int SW = $clog2(SB_TICK + 1);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  state_t          state, state_n;
  logic [SW-1:0]   s_cnt, s_n;
  logic [NW-1:0]   n_cnt, n_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic            par, par_n;
  logic            tx_reg, tx_n;
  logic            done_reg, done_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_n;
      s_cnt    <= s_n;
      n_cnt    <= n_n;
      shreg    <= shreg_n;
      par      <= par_n;
      tx_reg   <= tx_n;
      done_reg <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s_cnt;
    n_n     = n_cnt;
    shreg_n = shreg;
    par_n   = par;
    done_n  = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (i_tx_start) begin
          shreg_n = i_din;
          par_n   = (^i_din) ^ (PARITY_ODD != 0);
          s_n     = '0;
          state_n = START;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_cnt == S_LAST) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_cnt == S_LAST) begin
            s_n     = '0;
            shreg_n = shreg >> 1;
            if (n_cnt == N_LAST)
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
            else
              n_n = n_cnt + 1'b1;
          end else begin
            s_n = s_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (i_s_tick) begin
          if (s_cnt == S_LAST) begin
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_cnt == STOP_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            s_n = s_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        s_n     = '0;
        n_n     = '0;
      end
    endcase
    // line level follows the state being entered, so o_tx is glitch-free
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign o_tx           = tx_reg;
  assign o_tx_done_tick = done_reg;
  assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx: frames are decoded by
// mid-bit sampling and compared against an ideal frame model.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] start = '0;
  logic [3:0] tx, done, busy;
  logic tx_m, done_m, busy_m;
  int sel = 0;
  int tcnt = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // baud generator with LIMITE=4: one tick every 4 clocks
  always @(posedge clk) begin
    tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
    tick <= (tcnt == 3);
  end

  always_comb begin
    tx_m   = tx[sel];
    done_m = done[sel];
    busy_m = busy[sel];
  end

  uart_tx dut0 (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick),
    .i_tx_start(start[0]), .i_din(din),
    .o_tx(tx[0]), .o_tx_done_tick(done[0]), .o_busy(busy[0]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick),
    .i_tx_start(start[1]), .i_din(din),
    .o_tx(tx[1]), .o_tx_done_tick(done[1]), .o_busy(busy[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick),
    .i_tx_start(start[2]), .i_din(din),
    .o_tx(tx[2]), .o_tx_done_tick(done[2]), .o_busy(busy[2]));

  uart_tx #(.SB_TICK(32)) dut_sb (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick),
    .i_tx_start(start[3]), .i_din(din),
    .o_tx(tx[3]), .o_tx_done_tick(done[3]), .o_busy(busy[3]));

  // Ideal frame: 0, data LSB-first, optional parity; each bit 64 clocks,
  // start bit shortened by under one tick; done after the stop bit.
  task automatic check_frame(input logic [7:0] w, input bit pen,
                             input bit podd, input int stop_clks,
                             input string nm, output int waited);
    bit exp_bits[$];
    int nns, idx, lo, hi;
    bit got, eb;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
    if (pen) exp_bits.push_back(bit'(($countones(w) % 2) ^ podd));
    nns = exp_bits.size();
    waited = 0;
    while (tx_m !== 1'b0 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (tx_m !== 1'b0) begin
      fails++;
      $display("FAIL %s start_timeout tx=%b required 0", nm, tx_m);
      return;
    end
    idx = 0;
    got = 0;
    lo = nns * 64 + stop_clks - 3;
    hi = nns * 64 + stop_clks;
    while (!got && idx <= hi + 8) begin
      if (idx % 64 == 32 && idx / 64 <= nns) begin
        eb = (idx / 64 < nns) ? exp_bits[idx / 64] : 1'b1;
        tests++;
        if (tx_m !== eb || busy_m !== 1'b1) begin
          fails++;
          $display("FAIL %s bit%0d tx=%b busy=%b required tx=%b busy=1",
                   nm, idx / 64, tx_m, busy_m, eb);
        end
      end
      if (done_m === 1'b1) begin
        got = 1;
        tests++;
        if (idx < lo || idx > hi || busy_m !== 1'b0) begin
          fails++;
          $display("FAIL %s done_at=%0d busy=%b required %0d..%0d busy=0",
                   nm, idx, busy_m, lo, hi);
        end
      end else begin
        @(negedge clk);
        idx++;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s done_timeout idx=%0d required done by %0d", nm, idx, hi);
    end
  endtask

  task automatic pulse_start(input int s, input logic [7:0] w);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    din = w;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic idle_check(input int n, input string nm);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s idle_violations=%0d required 0", nm, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      tests++;
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d tx=%b busy=%b done=%b required 1/0/0",
                 s, tx_m, busy_m, done_m);
      end
    end
    sel = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check(200, "reset_idle");
  endtask

  task automatic test_frame();
    int wt;
    logic [7:0] w;
    sel = 0;
    pulse_start(0, 8'hA5);
    check_frame(8'hA5, 0, 0, 64, "frame_a5", wt);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      w = 8'($urandom);
      pulse_start(0, w);
      check_frame(w, 0, 0, 64, "frame_rand", wt);
    end
  endtask

  task automatic test_ignore_start();
    int wt;
    sel = 0;
    @(negedge clk);
    pulse_start(0, 8'hA5);
    fork
      check_frame(8'hA5, 0, 0, 64, "ignore_start", wt);
      begin
        repeat (4 * 64 + 10) @(negedge clk);
        din = 8'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    idle_check(200, "no_second_frame");
  endtask

  task automatic test_parity();
    int wt;
    logic [7:0] w;
    sel = 1;
    @(negedge clk);
    pulse_start(1, 8'h07);
    check_frame(8'h07, 1, 0, 64, "parity_even_07", wt);
    sel = 2;
    @(negedge clk);
    pulse_start(2, 8'h07);
    check_frame(8'h07, 1, 1, 64, "parity_odd_07", wt);
    for (int k = 0; k < 4; k++) begin
      sel = 1 + (k % 2);
      w = 8'($urandom);
      @(negedge clk);
      pulse_start(sel, w);
      check_frame(w, 1, bit'(k % 2), 64, "parity_rand", wt);
    end
  endtask

  task automatic test_async_reset();
    int wt;
    int dn = 0;
    sel = 0;
    @(negedge clk);
    pulse_start(0, 8'($urandom));
    repeat (5 * 64 + 30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (tx_m !== 1'b1 || busy_m !== 1'b0) begin
      fails++;
      $display("FAIL async_reset tx=%b busy=%b required 1/0", tx_m, busy_m);
    end
    repeat (3) begin
      @(negedge clk);
      if (done_m !== 1'b0) dn++;
    end
    rst = 1'b0;
    tests++;
    if (dn != 0) begin
      fails++;
      $display("FAIL reset_done_pulses=%0d required 0", dn);
    end
    idle_check(20, "post_reset_idle");
    pulse_start(0, 8'h3C);
    check_frame(8'h3C, 0, 0, 64, "frame_3c", wt);
  endtask

  task automatic test_back_to_back();
    int wt;
    sel = 3;
    @(negedge clk);
    din = 8'h55;
    start[3] = 1'b1;
    @(negedge clk);
    check_frame(8'h55, 0, 0, 128, "b2b_f1", wt);
    check_frame(8'h55, 0, 0, 128, "b2b_f2", wt);
    tests++;
    if (wt != 1) begin
      fails++;
      $display("FAIL b2b_gap2 clocks=%0d required 1", wt);
    end
    @(negedge clk);
    start[3] = 1'b0;
    tests++;
    if (tx_m !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap3 tx=%b required 0", tx_m);
    end
    check_frame(8'h55, 0, 0, 128, "b2b_f3", wt);
    idle_check(300, "b2b_end_idle");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignore_start();
    test_parity();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
